// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared types and sizing helpers for pulse_sched
package pulse_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  localparam int MERGE_CNT_W = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int width, input int gap);
    return $clog2(max_int(width, gap) + 1);
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// rtl/pulse_sched_rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eff,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] winner
);

  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && eff[(int'(ptr) + i) % N]) begin
        any    = 1'b1;
        winner = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// rtl/pulse_sched.sv - round-robin sharing of one strobe-to-pulse output between N_REQ requesters
// Optional merge counter enabled by PULSE_SCHED_MERGE_CNT_EN.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [N_REQ-1:0]         req,
  output logic                     pulseo,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic [N_REQ-1:0]         pending
`ifdef PULSE_SCHED_MERGE_CNT_EN
  ,
  input  logic                     merge_clr,
  output logic [MERGE_CNT_W-1:0]   merge_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] G_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win;
  logic              any;
  logic [N_REQ-1:0]  eff;
  logic [N_REQ-1:0]  gnt_vec;
  logic              at_end_pulse;
  logic              at_end_gap;
  logic              do_grant;

  assign eff = pending | (req & {N_REQ{ena}});

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .eff    (eff),
    .ptr    (ptr),
    .any    (any),
    .winner (win)
  );

  assign at_end_pulse = (state == S_PULSE) && (cnt == W_LAST);
  assign at_end_gap   = (GAP > 0) && (state == S_GAP) && (cnt == G_LAST);
  // With no guard interval the end of a pulse is itself an arbitration point.
  assign do_grant     = any && ((state == S_IDLE) || at_end_gap || (at_end_pulse && (GAP == 0)));
  assign gnt_vec      = do_grant ? (N_REQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      pulseo  <= 1'b0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      pending <= '0;
    end else begin
      pending <= eff & ~gnt_vec;
      if (do_grant) begin
        pulseo <= 1'b1;
        gnt_id <= win;
        ptr    <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        cnt    <= '0;
        state  <= S_PULSE;
        busy   <= 1'b1;
      end else begin
        case (state)
          S_PULSE: begin
            if (cnt == W_LAST) begin
              pulseo <= 1'b0;
              cnt    <= '0;
              if (GAP > 0) begin
                state <= S_GAP;
                busy  <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (cnt == G_LAST) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PULSE_SCHED_MERGE_CNT_EN
  localparam int MW1 = MERGE_CNT_W + 1;

  logic [N_REQ-1:0] merged;
  logic [MW1-1:0]   merge_sum;

  assign merged = req & {N_REQ{ena}} & pending;

  always_comb begin
    merge_sum = {1'b0, merge_cnt};
    for (int i = 0; i < N_REQ; i++) begin
      merge_sum = merge_sum + MW1'(merged[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_cnt <= '0;
    end else if (merge_clr) begin
      merge_cnt <= '0;
    end else if (merge_sum[MERGE_CNT_W]) begin
      merge_cnt <= '1;
    end else begin
      merge_cnt <= merge_sum[MERGE_CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// tb/tb_pulse_sched.sv - random and directed checks of pulse_sched against a timeline reference model
// Instance 0 uses GAP=2, instance 1 uses GAP=0; both share the same stimulus.
module tb_pulse_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] req;
  logic       p0, p1, b0, b1;
  logic [1:0] g0, g1;
  logic [3:0] pd0, pd1;
`ifdef PULSE_SCHED_MERGE_CNT_EN
  logic        mclr;
  logic [15:0] mc0, mc1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;

  // Per-instance timeline model: latest pulse start, first cycle free for a new pulse.
  int w_p[2] = '{4, 4};
  int g_p[2] = '{2, 0};
  int mpend[2], mptr[2], mpstart[2], mgid[2], mfree[2], mmerge[2];

  always #5 clk = ~clk;

  pulse_sched #(.N_REQ(4), .WIDTH(4), .GAP(2)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .req(req),
    .pulseo(p0), .gnt_id(g0), .busy(b0), .pending(pd0)
`ifdef PULSE_SCHED_MERGE_CNT_EN
    , .merge_clr(mclr), .merge_cnt(mc0)
`endif
  );

  pulse_sched #(.N_REQ(4), .WIDTH(4), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .req(req),
    .pulseo(p1), .gnt_id(g1), .busy(b1), .pending(pd1)
`ifdef PULSE_SCHED_MERGE_CNT_EN
    , .merge_clr(mclr), .merge_cnt(mc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int exp_pulse(input int i, input int c);
    return (c >= mpstart[i] && c < mpstart[i] + w_p[i]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mpend[i] = 0; mptr[i] = 0; mpstart[i] = -1000; mgid[i] = 0; mfree[i] = 0; mmerge[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input int r, input bit e, input bit clr);
    int eff, pc, id;
    bit found;
    eff = mpend[i] | (e ? r : 0);
    pc = 0;
    for (int b = 0; b < N; b++) if (e && r[b] && mpend[i][b]) pc++;
    if (clr) mmerge[i] = 0;
    else mmerge[i] = (mmerge[i] + pc > 65535) ? 65535 : mmerge[i] + pc;
    found = 0;
    if (cyc + 1 >= mfree[i] && eff != 0) begin
      for (int j = 0; j < N; j++) begin
        id = (mptr[i] + j) % N;
        if (!found && eff[id]) begin
          found = 1;
          mgid[i] = id;
          mpstart[i] = cyc + 1;
          mfree[i] = cyc + 1 + w_p[i] + g_p[i];
          mptr[i] = (id + 1) % N;
          eff = eff & ~(1 << id);
        end
      end
    end
    mpend[i] = eff;
  endtask

  task automatic check_outputs();
    chk("pulse0", p0, exp_pulse(0, cyc));
    chk("busy0", b0, (cyc < mfree[0]) ? 1 : 0);
    chk("pend0", pd0, mpend[0]);
    if (exp_pulse(0, cyc) == 1) chk("gnt0", g0, mgid[0]);
    chk("pulse1", p1, exp_pulse(1, cyc));
    chk("busy1", b1, (cyc < mfree[1]) ? 1 : 0);
    chk("pend1", pd1, mpend[1]);
    if (exp_pulse(1, cyc) == 1) chk("gnt1", g1, mgid[1]);
`ifdef PULSE_SCHED_MERGE_CNT_EN
    chk("merge0", mc0, mmerge[0]);
    chk("merge1", mc1, mmerge[1]);
`endif
  endtask

  task automatic step(input logic [3:0] r, input logic e);
    bit clr;
    clr = 0;
`ifdef PULSE_SCHED_MERGE_CNT_EN
    clr = mclr;
`endif
    check_outputs();
    req = r;
    ena = e;
    for (int i = 0; i < 2; i++) model_edge(i, int'(r), e, clr);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    #1;
    chk("rst_pulse0", p0, 0);
    chk("rst_pulse1", p1, 0);
    chk("rst_pend0", pd0, 0);
    chk("rst_busy0", b0, 0);
    chk("rst_gnt0", g0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    req = '0;
`ifdef PULSE_SCHED_MERGE_CNT_EN
    mclr = 1'b0;
`endif
    cyc = 0;
    @(negedge clk);
    do_reset();
    cyc = 0;

    // single strobe at cycle 10
    repeat (10) step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    repeat (10) step(4'b0000, 1'b1);
    // all requesters at once
    step(4'b1111, 1'b1);
    repeat (30) step(4'b0000, 1'b1);
    // pointer wrap
    step(4'b1000, 1'b1);
    repeat (8) step(4'b0000, 1'b1);
    step(4'b1001, 1'b1);
    repeat (15) step(4'b0000, 1'b1);
    // back-to-back pair
    step(4'b0011, 1'b1);
    repeat (14) step(4'b0000, 1'b1);
    // ena low ignores strobes
    step(4'b0100, 1'b0);
    repeat (4) step(4'b0000, 1'b1);
    // repeated strobes on one bit during another pulse
    step(4'b0001, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b1);
    repeat (20) step(4'b0000, 1'b1);
`ifdef PULSE_SCHED_MERGE_CNT_EN
    mclr = 1'b1;
    step(4'b0000, 1'b1);
    mclr = 1'b0;
`endif
    // reset while a pulse is in flight with a request pending
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    do_reset();
    step(4'b1111, 1'b1);
    repeat (20) step(4'b0000, 1'b1);

    repeat (3000) begin
      logic [3:0] r;
      logic e;
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      e = ($urandom_range(0, 7) != 0);
`ifdef PULSE_SCHED_MERGE_CNT_EN
      mclr = ($urandom_range(0, 63) == 0);
`endif
      if ($urandom_range(0, 499) == 0) do_reset();
      step(r, e);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_sched.md
Name: pulse_sched

Overview:
- Shares one strobe-to-pulse output between N_REQ requesters, for example the encoder reset, field-sync and register-latch strobes.
- Per-requester strobes are latched as pending and served round-robin.
- Each grant produces a WIDTH-cycle high pulse, followed by a GAP-cycle low guard interval.
- The granted requester ID is reported alongside the pulse so downstream logic can qualify it.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 4, pulse high time in clk cycles (>=1)
GAP, 2, forced low cycles between consecutive pulses (>=0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ena  in  1  global strobe qualifier; when low, new strobes are ignored
req  in  N_REQ  single-cycle strobes, one bit per requester
pulseo  out  1  shared output pulse
gnt_id  out  $clog2(N_REQ)  ID owning the current pulse; valid while pulseo=1
busy  out  1  high in PULSE or GAP state
pending  out  N_REQ  latched, not-yet-served requests

Behaviour:
- Reset (async, rst=1): pulseo=0, gnt_id=0, busy=0, pending=0, state=IDLE, round-robin pointer=0 (req[0] has top priority), cycle counter=0.
- Effective request vector: eff = pending | (req & {N_REQ{ena}}).
- States:
  - IDLE: if eff!=0, grant the first set bit of eff searching from the pointer upward with wrap. At that edge: pulseo<=1, gnt_id<=winner, pointer<=winner+1 mod N_REQ, cnt<=0, go to PULSE. Latency is one cycle from a strobe sampled in IDLE to pulseo high.
  - PULSE: pulseo high for exactly WIDTH cycles; cnt increments each cycle. At cnt==WIDTH-1:
    - GAP>0: pulseo<=0, cnt<=0, go to GAP.
    - GAP==0 and eff!=0: re-arbitrate immediately. pulseo stays 1, gnt_id changes, and a new WIDTH-cycle pulse begins.
    - GAP==0 and eff==0: pulseo<=0, go to IDLE.
  - GAP: pulseo=0 for exactly GAP cycles. At cnt==GAP-1, arbitrate exactly as IDLE does. If eff!=0, pulseo rises on that edge; otherwise go to IDLE.
- Pending rules:
  - Bit i sets on req[i]&ena in any state.
  - Bit i clears on the edge where i is granted. A req[i] arriving on that same edge while not being granted stays pending. A req[i] that is itself the grant source is consumed.
  - Repeat strobes on an already-pending bit merge; there is no queue depth.
- busy = (state != IDLE), registered.
- ena low: strobes are ignored, but existing pending bits and an in-flight pulse/gap complete normally.
- Simultaneous strobes on all requesters: served in pointer order, one pulse each. With GAP>0 the period is WIDTH+GAP cycles per pulse.
- Pointer wrap: winner N_REQ-1 sets the pointer to 0.
- Reset asserted mid-pulse: pulseo drops asynchronously and all pending requests are lost.
- cnt width = $clog2(max(WIDTH,GAP)+1). cnt never exceeds max(WIDTH,GAP)-1.

Optional Feature:
PULSE_SCHED_MERGE_CNT_EN
- Defined:
  - Adds output merge_cnt [15:0]: saturating count of strobes that arrived while their pending bit was already set (merged, i.e. lost).
  - Also adds input merge_clr (1), which synchronously zeroes the count. If merge_clr and a merge occur in the same cycle, the result is 0.
  - Reset value 0. Saturates at 16'hFFFF.
- Undefined: no ports, no logic; behaviour otherwise identical.

Decomposition:
- Package pulse_sched_pkg:
  - state enum {IDLE, PULSE, GAP}
  - max_int function
  - cnt-width helper function
  - MERGE_CNT_W=16 constant
- Sub-module rr_arbiter: combinational. Inputs: eff vector and pointer. Outputs: any and winner index. Reusable by other shared-strobe controllers.

Test Plan:
1. WIDTH=4, GAP=2, req=0001 at cycle 10 -> pulseo high in cycles 11-14, gnt_id=0, busy low from cycle 17, pending=0 after cycle 11.
2. req=1111 in one cycle -> four pulses with gnt_id 0,1,2,3, pulseo rising every 6 cycles, pending shrinking 1110→1100→1000→0000.
3. Pointer wrap: first serve id3, then req=1001 -> id0 is granted before id3.
4. GAP=0, req=0011 -> pulseo high for 8 continuous cycles, gnt_id switching 0→1 at cycle 4.
5. ena=0 with req=0100 -> no pulse and pending=0. Separately, assert rst in the middle of PULSE -> pulseo=0 at once, pending=0, pointer=0.
6. With PULSE_SCHED_MERGE_CNT_EN: req[2] strobed 3 times during another requester's pulse -> merge_cnt=2. merge_clr -> 0.
